// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
// Optional feature macro used by the top: SEQDET_COUNT_EN (saturating match counter).
package seq_det_pkg;

  typedef enum logic [1:0] {
    FILL_EMPTY   = 2'b00,
    FILL_FILLING = 2'b01,
    FILL_ARMED   = 2'b10
  } fill_state_e;

  localparam logic MODE_OVERLAP = 1'b1;
  localparam logic MODE_NONOVL  = 1'b0;

  // Fill must be able to represent 0..PAT_W inclusive.
  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  function automatic fill_state_e fill_state(input int fill, input int pat_w);
    fill_state_e st;
    if (fill == 0) begin
      st = FILL_EMPTY;
    end else if (fill < pat_w) begin
      st = FILL_FILLING;
    end else begin
      st = FILL_ARMED;
    end
    return st;
  endfunction

endpackage

// File: rtl/seq_det_history.sv
// History shift register and saturating fill counter for seq_detector_param.
// Exposes the post-shift candidate values so the parent can evaluate a match before committing.
module seq_det_history
  import seq_det_pkg::*;
#(
  parameter int PAT_W  = 4,
  parameter int FILL_W = fill_width(PAT_W)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              shift,
  input  logic              bit_in,
  input  logic              flush,
  input  logic              clear_fill,
  output logic [PAT_W-1:0]  hist_q,
  output logic [FILL_W-1:0] fill_q,
  output logic [PAT_W-1:0]  hist_shift_s,
  output logic [FILL_W-1:0] fill_shift_s
);

  logic [PAT_W-1:0]  hist_d;
  logic [FILL_W-1:0] fill_d;

  // Next history/fill: flush dominates, clear_fill only applies to a shift edge.
  always_comb begin
    hist_shift_s = {hist_q[PAT_W-2:0], bit_in};
    fill_shift_s = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
    hist_d       = hist_q;
    fill_d       = fill_q;
    if (flush) begin
      hist_d = {PAT_W{1'b0}};
      fill_d = {FILL_W{1'b0}};
    end else if (shift) begin
      hist_d = hist_shift_s;
      fill_d = clear_fill ? {FILL_W{1'b0}} : fill_shift_s;
    end else begin
      hist_d = hist_q;
      fill_d = fill_q;
    end
  end

  // History and fill registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist_q <= {PAT_W{1'b0}};
      fill_q <= {FILL_W{1'b0}};
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with overlap/non-overlap modes and registered outputs.
// Define SEQDET_COUNT_EN to build the saturating match counter; otherwise match_count is tied to 0.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             x_in,
  input  logic             x_valid,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             y_out,
  output logic             busy,
  output logic [CNT_W-1:0] match_count
);

  localparam int FILL_W = fill_width(PAT_W);

  logic [PAT_W-1:0]  pat_q, pat_d;
  logic              ovl_q, ovl_d;
  logic              y_out_q, y_out_d;
  logic              busy_q, busy_d;
  logic [PAT_W-1:0]  hist_q, hist_shift_s;
  logic [FILL_W-1:0] fill_q, fill_shift_s, fill_next_s;
  logic              shift_s, match_s, clear_fill_s;
  fill_state_e       state_nxt_s;

  seq_det_history #(
    .PAT_W (PAT_W),
    .FILL_W(FILL_W)
  ) u_history (
    .clock       (clock),
    .reset       (reset),
    .shift       (shift_s),
    .bit_in      (x_in),
    .flush       (load),
    .clear_fill  (clear_fill_s),
    .hist_q      (hist_q),
    .fill_q      (fill_q),
    .hist_shift_s(hist_shift_s),
    .fill_shift_s(fill_shift_s)
  );

  // Match evaluation, mode control and next-state decode of the fill FSM.
  always_comb begin
    pat_d        = pat_q;
    ovl_d        = ovl_q;
    shift_s      = x_valid && !load;
    match_s      = shift_s && (fill_shift_s == FILL_W'(PAT_W)) && (hist_shift_s == pat_q);
    clear_fill_s = match_s && (ovl_q == MODE_NONOVL);
    fill_next_s  = fill_q;
    if (load) begin
      pat_d       = pattern;
      ovl_d       = overlap;
      fill_next_s = {FILL_W{1'b0}};
    end else if (shift_s) begin
      fill_next_s = clear_fill_s ? {FILL_W{1'b0}} : fill_shift_s;
    end else begin
      fill_next_s = fill_q;
    end
    state_nxt_s = fill_state(int'(fill_next_s), PAT_W);
    case (state_nxt_s)
      FILL_EMPTY:   busy_d = 1'b0;
      FILL_FILLING: busy_d = 1'b1;
      FILL_ARMED:   busy_d = 1'b1;
      default:      busy_d = 1'b0;
    endcase
    y_out_d = match_s;
  end

  // Pattern/mode capture and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pat_q   <= {PAT_W{1'b0}};
      ovl_q   <= MODE_OVERLAP;
      y_out_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      y_out_q <= y_out_d;
      busy_q  <= busy_d;
    end
  end

  assign y_out = y_out_q;
  assign busy  = busy_q;

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  // Saturating match counter; load does not clear it.
  always_comb begin
    if (match_s && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign match_count = count_q;
`else
  assign match_count = {CNT_W{1'b0}};
`endif

endmodule
